// File: rtl/run_ctrl_if.sv
// Run-control bundle. It groups the board inputs, the core-side inputs and the
// run-control status outputs. The run_ctrl block uses the master view. The
// board/core side uses the slave view.
interface run_ctrl_if #(
  parameter int PC_WIDTH  = 16,
  parameter int NUM_BP    = 2,
  parameter int CNT_WIDTH = 32
);
  localparam int IDX_WIDTH = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic                       exec_btn;
  logic                       step_mode;
  logic                       halt;
  logic [PC_WIDTH-1:0]        pc;
  logic [NUM_BP*PC_WIDTH-1:0] bp_addr;
  logic [NUM_BP-1:0]          bp_en;
  logic                       cpu_en;
  logic [1:0]                 state;
  logic                       step_done;
  logic                       bp_hit;
  logic [IDX_WIDTH-1:0]       bp_idx;
  logic [CNT_WIDTH-1:0]       cycle;

  modport master (
    input  exec_btn, step_mode, halt, pc, bp_addr, bp_en,
    output cpu_en, state, step_done, bp_hit, bp_idx, cycle
  );

  modport slave (
    output exec_btn, step_mode, halt, pc, bp_addr, bp_en,
    input  cpu_en, state, step_done, bp_hit, bp_idx, cycle
  );
endinterface

// File: rtl/run_ctrl.sv
// Run-control unit for the pipelined processor. It debounces the exec button
// and runs a STOP/RUN/STEP/HALTED machine. The machine drives a registered
// clock enable, stops on PC breakpoints and counts the enabled cycles.
module run_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int          DEB_WIDTH  = 20,
  parameter int          PC_WIDTH   = 16,
  parameter int          NUM_BP     = 2,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic      clk,
  input  logic      reset,
  run_ctrl_if.master bus
);
  localparam int IDX_WIDTH = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       sync1, sync2;
  logic                       deb_level;
  logic [DEB_WIDTH-1:0]       deb_cnt;
  logic                       deb_flip;
  logic                       press;
  logic [NUM_BP*PC_WIDTH-1:0] bp_addr_q;
  logic [NUM_BP-1:0]          bp_en_q;
  logic                       bp_match;
  logic [IDX_WIDTH-1:0]       match_idx;
  logic                       skip_q, skip_d;
  logic                       bp_hit_q, bp_hit_d;
  logic                       bp_load;
  logic [IDX_WIDTH-1:0]       bp_idx_q;
  logic                       cpu_en_q;
  logic                       step_done_q;
  logic [CNT_WIDTH-1:0]       cycle_q;

  // The new level is accepted on the last of DEB_CYCLES disagreeing samples.
  // Only the rising acceptance is a press.
  assign deb_flip = (sync2 != deb_level) && (deb_cnt == DEB_LAST);
  assign press    = deb_flip && sync2;

  // Two-flop synchroniser for the asynchronous exec button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.exec_btn;
      sync2 <= sync1;
    end
  end

  // Debounce counter: it counts consecutive disagreeing samples and restarts
  // on any agreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (sync2 == deb_level) begin
      deb_cnt <= '0;
    end else if (deb_flip) begin
      deb_level <= sync2;
      deb_cnt   <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // Breakpoint setup is registered. Edits therefore apply from the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_addr_q <= '0;
      bp_en_q   <= '0;
    end else begin
      bp_addr_q <= bus.bp_addr;
      bp_en_q   <= bus.bp_en;
    end
  end

  // Compare the live PC against every enabled breakpoint. The downward scan
  // lets the lowest matching index win.
  always_comb begin
    bp_match  = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bus.pc == bp_addr_q[i*PC_WIDTH +: PC_WIDTH])) begin
        bp_match  = 1'b1;
        match_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Next-state logic. Within RUN the priority is halt, then breakpoint, then press.
  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    bp_hit_d = bp_hit_q;
    bp_load  = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (press) begin
          state_d  = bus.step_mode ? ST_STEP : ST_RUN;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      ST_RUN: begin
        skip_d = 1'b0;
        if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (bp_match && !skip_q) begin
          state_d  = ST_STOP;
          bp_hit_d = 1'b1;
          bp_load  = 1'b1;
        end else if (press) begin
          state_d = ST_STOP;
        end
      end
      ST_STEP: begin
        skip_d  = 1'b0;
        state_d = bus.halt ? ST_HALTED : ST_STOP;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_STOP;
    endcase
  end

  // State register. It also holds the registered enable and the status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_STOP;
      skip_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      bp_idx_q    <= '0;
      cpu_en_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      cpu_en_q    <= (state_d == ST_RUN) || (state_d == ST_STEP);
      step_done_q <= (state_q == ST_STEP);
      if (bp_load) begin
        bp_idx_q <= match_idx;
      end
    end
  end

  // Count the enabled cycles. The count sticks at all-ones and does not wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
    end else if (cpu_en_q && (cycle_q != '1)) begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.state     = state_q;
  assign bus.step_done = step_done_q;
  assign bus.bp_hit    = bp_hit_q;
  assign bus.bp_idx    = bp_idx_q;
  assign bus.cycle     = cycle_q;
endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl. A 32-bit-counter instance and a 4-bit-counter
// instance share the same stimulus. Both are checked against a cycle-level
// behavioural model.
module tb_run_ctrl;
  localparam int DEB = 4;
  localparam int PCW = 16;
  localparam int NBP = 2;
  localparam int M_STOP = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  run_ctrl_if #(.PC_WIDTH(PCW), .NUM_BP(NBP), .CNT_WIDTH(32)) bus ();
  run_ctrl_if #(.PC_WIDTH(PCW), .NUM_BP(NBP), .CNT_WIDTH(4))  sat_bus ();

  assign sat_bus.exec_btn  = bus.exec_btn;
  assign sat_bus.step_mode = bus.step_mode;
  assign sat_bus.halt      = bus.halt;
  assign sat_bus.pc        = bus.pc;
  assign sat_bus.bp_addr   = bus.bp_addr;
  assign sat_bus.bp_en     = bus.bp_en;

  run_ctrl #(.DEB_CYCLES(DEB), .DEB_WIDTH(4), .PC_WIDTH(PCW), .NUM_BP(NBP), .CNT_WIDTH(32))
    dut (.clk(clk), .reset(reset), .bus(bus));
  run_ctrl #(.DEB_CYCLES(DEB), .DEB_WIDTH(4), .PC_WIDTH(PCW), .NUM_BP(NBP), .CNT_WIDTH(4))
    dut_sat (.clk(clk), .reset(reset), .bus(sat_bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  int          m_state;
  bit          m_en, m_done, m_hit, m_deb, m_guard;
  int          m_idx;
  longint      m_cnt;
  bit          m_hist[$];
  logic [31:0] m_bpa;
  logic [1:0]  m_bpe;
  bit          ramp = 0;

  function automatic void model_clear();
    m_state = M_STOP; m_en = 0; m_done = 0; m_hit = 0; m_deb = 0; m_guard = 0;
    m_idx = 0; m_cnt = 0; m_bpa = '0; m_bpe = '0;
    m_hist.delete();
    for (int i = 0; i < DEB + 2; i++) m_hist.push_back(1'b0);
  endfunction

  function automatic longint sat_exp();
    return (m_cnt > 15) ? 15 : m_cnt;
  endfunction

  // One clock: sample the inputs, advance the model at the rising edge, and
  // return at the falling edge. When ramp is set, the PC moves like a core.
  task automatic tick();
    bit raw, sm, hl, press, match, en_pre, all_diff;
    logic [15:0] p;
    logic [31:0] ba;
    logic [1:0]  be;
    int midx, nxt;
    raw = bus.exec_btn; sm = bus.step_mode; hl = bus.halt;
    p = bus.pc; ba = bus.bp_addr; be = bus.bp_en; en_pre = m_en;
    @(posedge clk);
    // The synchronised sample lags the raw pin by two edges. A new level
    // needs DEB consecutive disagreeing samples.
    m_hist.push_front(raw);
    void'(m_hist.pop_back());
    all_diff = 1;
    for (int i = 2; i < DEB + 2; i++) if (m_hist[i] == m_deb) all_diff = 0;
    press = 0;
    if (all_diff) begin m_deb = !m_deb; press = m_deb; end
    match = 0; midx = 0;
    for (int i = NBP - 1; i >= 0; i--)
      if (m_bpe[i] && p == m_bpa[i*PCW +: PCW]) begin match = 1; midx = i; end
    m_bpa = ba; m_bpe = be;
    if (m_en) m_cnt++;
    m_done = (m_state == M_STEP);
    nxt = m_state;
    case (m_state)
      M_STOP: if (press) begin nxt = sm ? M_STEP : M_RUN; m_hit = 0; m_guard = 1; end
      M_RUN: begin
        if (hl) nxt = M_HALT;
        else if (match && !m_guard) begin nxt = M_STOP; m_hit = 1; m_idx = midx; end
        else if (press) nxt = M_STOP;
        m_guard = 0;
      end
      M_STEP: nxt = hl ? M_HALT : M_STOP;
      default: ;
    endcase
    m_state = nxt;
    m_en = (nxt == M_RUN) || (nxt == M_STEP);
    @(negedge clk);
    if (ramp && en_pre) bus.pc = bus.pc + 16'd1;
  endtask

  task automatic assert_reset();
    #2 reset = 1'b0;
    model_clear();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_reset();
    assert_reset();
    release_reset();
  endtask

  // Hold the button long enough for one press, then release it fully.
  task automatic press_button();
    bus.exec_btn = 1'b1;
    repeat (DEB + 3) tick();
    bus.exec_btn = 1'b0;
    repeat (DEB + 3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.exec_btn = 0; bus.step_mode = 0; bus.halt = 0; bus.pc = '0;
    bus.bp_addr = '0; bus.bp_en = '0;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0 || bus.step_done !== 1'b0)
      begin failures++; $display("FAIL reset_ctrl state=%0d en=%0b done=%0b want 0/0/0", bus.state, bus.cpu_en, bus.step_done); end
    checks++;
    if (bus.bp_hit !== 1'b0 || bus.bp_idx !== 1'b0 || bus.cycle !== 32'd0 || sat_bus.cycle !== 4'd0)
      begin failures++; $display("FAIL reset_status hit=%0b idx=%0d cyc=%0d sat=%0d want all 0", bus.bp_hit, bus.bp_idx, bus.cycle, sat_bus.cycle); end
    release_reset();
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.exec_btn = (i % 2 == 0);
      tick();
      checks++;
      if (bus.state !== 2'd0) begin failures++; $display("FAIL bounce_idle i=%0d state=%0d want 0", i, bus.state); end
    end
    bus.exec_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (bus.state !== ((k >= 6) ? 2'd1 : 2'd0) || bus.state !== 2'(m_state))
        begin failures++; $display("FAIL bounce_hold k=%0d state=%0d want %0d", k, bus.state, (k >= 6) ? 1 : 0); end
    end
    bus.exec_btn = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (bus.state !== 2'd1) begin failures++; $display("FAIL bounce_release k=%0d state=%0d want 1", k, bus.state); end
    end
  endtask

  task automatic test_run_stop();
    do_reset();
    bus.step_mode = 1'b0;
    press_button();
    checks++;
    if (bus.state !== 2'd1 || bus.cpu_en !== 1'b1)
      begin failures++; $display("FAIL run_start state=%0d en=%0b want 1/1", bus.state, bus.cpu_en); end
    repeat (20) tick();
    press_button();
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0)
      begin failures++; $display("FAIL run_stop state=%0d en=%0b want 0/0", bus.state, bus.cpu_en); end
    checks++;
    if (bus.cycle !== 32'd34 || bus.cycle !== 32'(m_cnt))
      begin failures++; $display("FAIL run_count got=%0d want 34 (model %0d)", bus.cycle, m_cnt); end
    repeat (10) tick();
    checks++;
    if (bus.cycle !== 32'd34) begin failures++; $display("FAIL run_hold got=%0d want 34", bus.cycle); end
  endtask

  task automatic test_single_step();
    int en_seen = 0, done_seen = 0;
    do_reset();
    bus.step_mode = 1'b1;
    for (int n = 0; n < 3; n++) begin
      bus.exec_btn = 1'b1;
      for (int t = 1; t <= 14; t++) begin
        if (t == 8) bus.exec_btn = 1'b0;
        tick();
        en_seen += int'(bus.cpu_en === 1'b1);
        done_seen += int'(bus.step_done === 1'b1);
        checks++;
        if (bus.state !== ((t == 6) ? 2'd2 : 2'd0) || bus.cpu_en !== (t == 6) || bus.step_done !== (t == 7))
          begin failures++; $display("FAIL step_seq n=%0d t=%0d state=%0d en=%0b done=%0b want %0d/%0b/%0b",
                 n, t, bus.state, bus.cpu_en, bus.step_done, (t == 6) ? 2 : 0, t == 6, t == 7); end
      end
    end
    checks++;
    if (en_seen != 3 || done_seen != 3 || bus.cycle !== 32'd3)
      begin failures++; $display("FAIL step_total en=%0d done=%0d cyc=%0d want 3/3/3", en_seen, done_seen, bus.cycle); end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bus.step_mode = 1'b0;
    bus.bp_addr = {16'h0010, 16'h0010};
    bus.bp_en = 2'b11;
    bus.pc = 16'h0000;
    ramp = 1;
    press_button();
    for (int i = 0; i < 40 && bus.state === 2'd1; i++) tick();
    checks++;
    if (bus.state !== 2'd0 || bus.bp_hit !== 1'b1 || bus.bp_idx !== 1'b0)
      begin failures++; $display("FAIL bp_stop state=%0d hit=%0b idx=%0d want 0/1/0", bus.state, bus.bp_hit, bus.bp_idx); end
    checks++;
    if (bus.cycle !== 32'd17) begin failures++; $display("FAIL bp_count got=%0d want 17", bus.cycle); end
    bus.pc = 16'h0010;
    press_button();
    checks++;
    if (bus.state !== 2'd1 || bus.bp_hit !== 1'b0 || bus.cycle !== 32'd25)
      begin failures++; $display("FAIL bp_resume state=%0d hit=%0b cyc=%0d want 1/0/25", bus.state, bus.bp_hit, bus.cycle); end
    bus.bp_addr = {16'h0020, 16'h0040};
    for (int i = 0; i < 40 && bus.state === 2'd1; i++) tick();
    checks++;
    if (bus.state !== 2'd0 || bus.bp_hit !== 1'b1 || bus.bp_idx !== 1'b1)
      begin failures++; $display("FAIL bp_idx1 state=%0d hit=%0b idx=%0d want 0/1/1", bus.state, bus.bp_hit, bus.bp_idx); end
    ramp = 0;
  endtask

  task automatic test_halt();
    do_reset();
    bus.step_mode = 1'b0;
    bus.bp_addr = {16'h0010, 16'h0010};
    bus.bp_en = 2'b11;
    bus.pc = 16'h0000;
    press_button();
    bus.exec_btn = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.state !== 2'd1) begin failures++; $display("FAIL halt_pre state=%0d want 1", bus.state); end
    bus.pc = 16'h0010;
    bus.halt = 1'b1;
    tick();
    checks++;
    if (bus.state !== 2'd3 || bus.bp_hit !== 1'b0 || bus.cpu_en !== 1'b0)
      begin failures++; $display("FAIL halt_dom state=%0d hit=%0b en=%0b want 3/0/0", bus.state, bus.bp_hit, bus.cpu_en); end
    bus.halt = 1'b0;
    bus.exec_btn = 1'b0;
    repeat (DEB + 3) tick();
    bus.step_mode = 1'b1;
    press_button();
    bus.step_mode = 1'b0;
    press_button();
    checks++;
    if (bus.state !== 2'd3 || bus.cycle !== 32'(m_cnt))
      begin failures++; $display("FAIL halt_sticky state=%0d cyc=%0d want 3/%0d", bus.state, bus.cycle, m_cnt); end
    assert_reset();
    #1;
    checks++;
    if (bus.state !== 2'd0) begin failures++; $display("FAIL halt_reset state=%0d want 0", bus.state); end
    release_reset();
    bus.bp_en = 2'b00;
  endtask

  task automatic test_async_reset_sat();
    do_reset();
    bus.step_mode = 1'b0;
    press_button();
    repeat (20) tick();
    checks++;
    if (sat_bus.cycle !== 4'hF || bus.cycle !== 32'd28)
      begin failures++; $display("FAIL sat_count sat=%0d main=%0d want 15/28", sat_bus.cycle, bus.cycle); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.state !== 2'd0 || bus.cpu_en !== 1'b0 || bus.cycle !== 32'd0 || sat_bus.cycle !== 4'd0)
      begin failures++; $display("FAIL async_reset state=%0d en=%0b cyc=%0d sat=%0d want 0/0/0/0", bus.state, bus.cpu_en, bus.cycle, sat_bus.cycle); end
    model_clear();
    release_reset();
  endtask

  task automatic test_random();
    int hold_left;
    for (int seg = 0; seg < 3; seg++) begin
      do_reset();
      hold_left = 0;
      ramp = 0;
      for (int n = 0; n < 250; n++) begin
        if (hold_left == 0) begin
          bus.exec_btn = 1'($urandom_range(0, 1));
          hold_left = $urandom_range(1, 10);
        end
        hold_left--;
        if ($urandom_range(0, 19) == 0) bus.step_mode = ~bus.step_mode;
        if (n % 40 == 0) begin
          bus.bp_addr = {16'($urandom_range(0, 7)), 16'($urandom_range(0, 7))};
          bus.bp_en = 2'($urandom_range(0, 3));
        end
        bus.pc = 16'($urandom_range(0, 7));
        bus.halt = ($urandom_range(0, 199) == 0);
        tick();
        checks++;
        if (bus.state !== 2'(m_state) || bus.cpu_en !== m_en || bus.step_done !== m_done ||
            bus.bp_hit !== m_hit || bus.bp_idx !== 1'(m_idx) || bus.cycle !== 32'(m_cnt) ||
            sat_bus.cycle !== 4'(sat_exp()))
          begin failures++;
            $display("FAIL rand seg=%0d n=%0d state %0d/%0d en %0b/%0b done %0b/%0b hit %0b/%0b idx %0d/%0d cyc %0d/%0d sat %0d/%0d",
                     seg, n, bus.state, m_state, bus.cpu_en, m_en, bus.step_done, m_done, bus.bp_hit, m_hit,
                     bus.bp_idx, m_idx, bus.cycle, m_cnt, sat_bus.cycle, sat_exp()); end
      end
      bus.halt = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_run_stop();
    test_single_step();
    test_breakpoint();
    test_halt();
    test_async_reset_sat();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Parametrised run-control unit for the pipelined processor.
- Produces a registered clock enable `cpu_en` that the core and memories qualify with, instead of gating the clock.
- Adds over the previous top-level scheme: a parametrised debouncer, run/stop toggle, single-step mode, PC breakpoints, and an enabled-cycle counter.
- Sits in the top module between board inputs (exec button, step switch) and the processor; consumes the core's halt and PC.

Parameters:
- DEB_CYCLES, 20'd500000: consecutive stable samples required to accept a new button level (>=2).
- DEB_WIDTH, 20: width of the debounce counter.
- PC_WIDTH, 16: width of pc and breakpoint addresses.
- NUM_BP, 2: number of breakpoint comparators (>=1).
- CNT_WIDTH, 32: enabled-cycle counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- exec_btn  in  1  raw exec button, 1 = pressed, asynchronous and bouncy.
- step_mode  in  1  0 = press toggles run/stop; 1 = press issues one step.
- halt  in  1  halt from the writeback stage (haltW).
- pc  in  PC_WIDTH  current fetch PC.
- bp_addr  in  NUM_BP*PC_WIDTH  breakpoint addresses; entry i is bits [i*PC_WIDTH +: PC_WIDTH].
- bp_en  in  NUM_BP  per-breakpoint enable.
- cpu_en  out  1  processor clock enable.
- state  out  2  0 = STOP, 1 = RUN, 2 = STEP, 3 = HALTED.
- step_done  out  1  one-cycle pulse after a step completes.
- bp_hit  out  1  sticky flag: last stop was caused by a breakpoint.
- bp_idx  out  clog2(NUM_BP) min 1  lowest matching breakpoint index.
- cycle  out  CNT_WIDTH  count of cycles with cpu_en=1.

Behaviour:
- Reset (reset=0, async) clears everything:
  - state=STOP, cpu_en=0, step_done=0, bp_hit=0, bp_idx=0, cycle=0.
  - Synchroniser flops, debounced level and debounce counter all cleared.
- Reset mid-run or mid-step forces STOP immediately, regardless of FSM state.
- Input path:
  - exec_btn passes through a 2-flop synchroniser.
  - The debounce counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments; on reaching DEB_CYCLES-1 the debounced level takes the new value and the counter clears.
  - `press` is a one-cycle pulse on the debounced 0->1 edge. Release generates nothing.
  - Press latency from a clean edge: 2 + DEB_CYCLES cycles.
- cpu_en is Moore: 1 exactly when the registered state is RUN or STEP.
- Transition priority, highest first: halt, breakpoint, press.
- STOP:
  - press & !step_mode -> RUN, with `skip` set.
  - press & step_mode -> STEP, with `skip` set.
  - Entering RUN or STEP clears bp_hit.
- RUN:
  - halt=1 -> HALTED.
  - Else breakpoint match & !skip -> STOP; set bp_hit, load bp_idx.
  - Else press -> STOP.
  - `skip` clears after the first RUN cycle, so resuming from a breakpoint PC does not re-hit it.
- STEP:
  - Lasts exactly one cycle, giving one cpu_en pulse.
  - Next state is STOP, or HALTED if halt=1.
  - step_done=1 on the cycle after STEP.
  - Breakpoints are ignored in STEP.
- HALTED: cpu_en=0. Press, breakpoints and step_mode are ignored; only reset exits.
- Breakpoint match:
  - Entry i matches when bp_en[i] & pc==bp_addr[i].
  - Multiple matches: lowest index wins.
  - bp_addr and bp_en changes take effect the next cycle.
- Stop timing: on a stop decision in cycle n, cpu_en is still 1 in cycle n and 0 from n+1. The core executes the matching fetch cycle once.
- cycle counter:
  - Increments on every clock edge where cpu_en=1.
  - Saturates at all-ones; no wrap.
- step_mode is sampled only in STOP; toggling it during RUN has no effect until the next press from STOP.

Test Plan:
- Bounce filter (DEB_CYCLES=4): exec_btn toggles every cycle for 10 cycles, then held 1 -> exactly one press; state goes 0->1 six cycles after the hold starts; no press on release.
- Run/stop: press, wait 20 cycles, press again (step_mode=0) -> state 1 then 0; cycle equals the cpu_en-high count (about 20 + debounce latency); cycle holds once stopped.
- Single step (step_mode=1): three presses -> three single-cycle cpu_en pulses, each followed by step_done; cycle=3; state returns to 0 after each.
- Breakpoints:
  - Setup: bp_addr0=16'h0010, bp_addr1=16'h0010, bp_en=2'b11, RUN, pc ramps from 0 by 1 -> stop on pc=16'h0010, bp_hit=1, bp_idx=0.
  - Resume with a press -> no immediate re-hit; runs on past 16'h0010 and bp_hit clears.
- Halt dominance: halt=1 asserted in the same cycle as a breakpoint match and a press -> state=3, bp_hit=0; further presses ignored; reset returns state 0.
- Async reset and saturation:
  - reset low mid-RUN between clock edges -> outputs clear with no clock edge.
  - CNT_WIDTH=4 running 20 cycles -> cycle=4'hF.
